// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmitter and its matching SIPO receiver.
package piso_pkg;

   // State encodings, shared with the receiver so both ends decode the same values
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_GAP   = 2'd2;

   // Width of the inter-word gap counter (GAP range 0..15)
   localparam int GAP_W = 4;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_SHIFT = ST_SHIFT,
      S_GAP   = ST_GAP
   } piso_state_e;

endpackage

// File: rtl/piso_serializer_if.sv
// Parallel-load handshake plus serial output bundle for the PISO serializer.
interface piso_serializer_if #(
   parameter int WIDTH = 4
) ();

   logic [WIDTH-1:0] pi_data;
   logic             pi_valid;
   logic             pi_ready;
   logic             shift_en;
   logic             so;
   logic             so_valid;
   logic             so_first;
   logic             so_last;
   logic             busy;

   // Producer / bit-rate source side
   modport master (
      output pi_data, pi_valid, shift_en,
      input  pi_ready, so, so_valid, so_first, so_last, busy
   );

   // Serializer side
   modport slave (
      input  pi_data, pi_valid, shift_en,
      output pi_ready, so, so_valid, so_first, so_last, busy
   );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with enable and zero flag; load wins over enable.
module piso_bit_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic [W-1:0] count_o,
   output logic         zero_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: load has priority, otherwise decrement on enable
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = count_q - W'(1);
      end
   end

   // Count register, cleared by asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign zero_o  = (count_q == '0);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and framing flags.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter int GAP       = 0
) (
   input  logic               clk,
   input  logic               rst,
   piso_serializer_if.slave   bus
);

   localparam int                 BW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [BW-1:0]      BIT_MAX = BW'(WIDTH - 1);
   localparam bit                 HAS_GAP = (GAP > 0);
   localparam logic [GAP_W-1:0]   GAP_LD  = HAS_GAP ? GAP_W'(GAP - 1) : '0;

   piso_state_e        state_q;
   logic [WIDTH-1:0]   shreg_q;
   logic [WIDTH-1:0]   shreg_shifted;
   logic [BW-1:0]      bit_cnt;
   logic               bit_zero;
   logic [GAP_W-1:0]   gap_cnt;
   logic               gap_zero;
   logic               accept;
   logic               in_shift;
   logic               in_gap;
   logic               word_done;
   logic               unused_gap_cnt;

   assign in_shift  = (state_q == S_SHIFT);
   assign in_gap    = (state_q == S_GAP);
   assign word_done = in_shift && bit_zero && bus.shift_en;

   // Ready is combinational so a new word can follow the last bit with no bubble
   assign bus.pi_ready = (state_q == S_IDLE) || (word_done && !HAS_GAP);
   assign accept       = bus.pi_valid && bus.pi_ready;

   // Shift toward the output end with zero fill
   assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shreg_q[WIDTH-1:1]};

   piso_bit_counter #(.W(BW)) u_bitcnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (accept),
      .load_val_i (BIT_MAX),
      .en_i       (in_shift && bus.shift_en && !bit_zero),
      .count_o    (bit_cnt),
      .zero_o     (bit_zero)
   );

   piso_bit_counter #(.W(GAP_W)) u_gapcnt (
      .clk        (clk),
      .rst        (rst),
      .load_i     (word_done && HAS_GAP),
      .load_val_i (GAP_LD),
      .en_i       (in_gap && bus.shift_en && !gap_zero),
      .count_o    (gap_cnt),
      .zero_o     (gap_zero)
   );

   assign unused_gap_cnt = ^gap_cnt;

   // Control FSM and shift register; reset aborts any word in flight
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         shreg_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  shreg_q <= bus.pi_data;
                  state_q <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bus.shift_en) begin
                  if (!bit_zero) begin
                     shreg_q <= shreg_shifted;
                  end else if (accept) begin
                     shreg_q <= bus.pi_data;
                  end else if (HAS_GAP) begin
                     state_q <= S_GAP;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
            end
            S_GAP: begin
               if (bus.shift_en && gap_zero) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.so_valid = in_shift;
   assign bus.so       = in_shift && (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
   assign bus.so_first = in_shift && (bit_cnt == BIT_MAX);
   assign bus.so_last  = in_shift && bit_zero;
   assign bus.busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: two instances (MSB-first/no gap, LSB-first/gap 2).
module tb_piso_serializer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic se  = 1'b0;
   int   se_mode = 0;
   int   tick = 0;
   int   nvec = 0;
   int   nerr = 0;

   logic [2:0] q0[$];
   logic [2:0] q1[$];

   piso_serializer_if #(.WIDTH(4)) if0 ();
   piso_serializer_if #(.WIDTH(4)) if1 ();

   assign if0.shift_en = se;
   assign if1.shift_en = se;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .GAP(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .GAP(2)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Expected {so, so_first, so_last} for each bit of a word, in transmit order
   task automatic push_word(input int which, input logic [3:0] w, input bit msb);
      for (int i = 0; i < 4; i++) begin
         int idx;
         logic [2:0] e;
         idx = msb ? 3 - i : i;
         e = {w[idx], (i == 0), (i == 3)};
         if (which == 0) q0.push_back(e);
         else            q1.push_back(e);
      end
   endtask

   task automatic send0(input logic [3:0] w);
      logic rdy;
      bit   done;
      done = 0;
      if0.pi_data  = w;
      if0.pi_valid = 1'b1;
      push_word(0, w, 1'b1);
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         rdy = if0.pi_ready;
         @(posedge clk);
         done = rdy;
      end
      if (!done) check_val("send0_timeout", 0, 1);
      #1;
   endtask

   task automatic send1(input logic [3:0] w);
      logic rdy;
      bit   done;
      done = 0;
      if1.pi_data  = w;
      if1.pi_valid = 1'b1;
      push_word(1, w, 1'b0);
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         rdy = if1.pi_ready;
         @(posedge clk);
         done = rdy;
      end
      if (!done) check_val("send1_timeout", 0, 1);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
      check_val("drain", q0.size() + q1.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   // Bit-rate tick generator
   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick++;
         se = (se_mode == 0) ? 1'b1 : (tick % 3 == 0);
      end
   end

   // Output monitor: pop expected bit when consumed, check hold and idle-zero
   logic [2:0] pv0 = '0, pv1 = '0;
   logic       pval0 = 1'b0, pval1 = 1'b0, pse0 = 1'b0, pse1 = 1'b0;
   always @(negedge clk) begin
      logic [2:0] c0, c1, e;
      c0 = {if0.so, if0.so_first, if0.so_last};
      c1 = {if1.so, if1.so_first, if1.so_last};
      if (if0.so_valid && se) begin
         if (q0.size() == 0) check_val("unexp_bit0", 1, 0);
         else begin e = q0.pop_front(); check_val("bit0", c0, e); end
      end
      if (if1.so_valid && se) begin
         if (q1.size() == 0) check_val("unexp_bit1", 1, 0);
         else begin e = q1.pop_front(); check_val("bit1", c1, e); end
      end
      if (if0.so_valid && pval0 && !pse0) check_val("hold0", c0, pv0);
      if (if1.so_valid && pval1 && !pse1) check_val("hold1", c1, pv1);
      if (!if0.so_valid) check_val("idle_so0", c0, 3'b000);
      if (!if1.so_valid) check_val("idle_so1", c1, 3'b000);
      pv0 = c0; pval0 = if0.so_valid; pse0 = se;
      pv1 = c1; pval1 = if1.so_valid; pse1 = se;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      if0.pi_data = '0; if0.pi_valid = 1'b0;
      if1.pi_data = '0; if1.pi_valid = 1'b0;

      // Reset values while held and after release
      repeat (3) @(negedge clk);
      check_val("rst_ready", if0.pi_ready, 1);
      check_val("rst_busy",  if0.busy, 0);
      check_val("rst_valid", if0.so_valid, 0);
      check_val("rst_so",    if0.so, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_val("rel_ready", {if0.pi_ready, if1.pi_ready}, 2'b11);
      check_val("rel_busy",  {if0.busy, if1.busy, if0.so_valid, if1.so_valid}, 4'b0000);

      // Single word, MSB first
      @(posedge clk); #1;
      send0(4'b1011);
      if0.pi_valid = 1'b0;
      @(negedge clk);
      check_val("t2_first", if0.so_first, 1);
      repeat (3) @(negedge clk);
      check_val("t2_last",  if0.so_last, 1);
      check_val("t2_ready", if0.pi_ready, 1);
      @(negedge clk);
      check_val("t2_done",  {if0.so_valid, if0.busy}, 2'b00);
      drain();

      // Back-to-back words with no bubble
      @(posedge clk); #1;
      send0(4'hA);
      fork
         send0(4'h5);
         begin
            for (int i = 0; i < 8; i++) begin
               @(negedge clk);
               check_val("t3_nobubble", if0.so_valid, 1);
            end
         end
      join
      if0.pi_valid = 1'b0;
      drain();

      // Slow bit rate: tick every third cycle
      se_mode = 1;
      @(posedge clk); #1;
      send0(4'b1011);
      if0.pi_valid = 1'b0;
      drain();
      se_mode = 0;
      repeat (2) @(negedge clk);

      // LSB first with two gap ticks
      @(posedge clk); #1;
      send1(4'b1011);
      if1.pi_valid = 1'b0;
      repeat (4) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_val("t5_gap_ready", if1.pi_ready, 0);
         check_val("t5_gap_valid", {if1.so_valid, if1.so, if1.busy}, 3'b001);
      end
      @(negedge clk);
      check_val("t5_ready", {if1.pi_ready, if1.busy}, 2'b10);
      drain();

      // Asynchronous reset mid-word, then a fresh word
      @(posedge clk); #1;
      send0(4'hC);
      if0.pi_valid = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_val("t6_rst_out", {if0.so, if0.so_valid, if0.so_first, if0.so_last, if0.busy, if0.pi_ready}, 6'b000001);
      check_val("t6_left", q0.size(), 2);
      q0.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      send0(4'h3);
      if0.pi_valid = 1'b0;
      @(negedge clk);
      check_val("t6_first", {if0.so, if0.so_first}, 2'b01);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
